// File: rtl/alarm_clock_multi.sv
// 24-hour real-time clock with a 1 Hz clock-enable prescaler, N loadable alarm
// slots, snooze, ring timeout and 12/24-hour BCD display decode.
module alarm_clock_multi #(
  parameter int CLK_HZ   = 10,
  parameter int N_ALARMS = 4,
  parameter int SNOOZE_S = 300,
  parameter int RING_S   = 60,
  localparam int AW      = $clog2(N_ALARMS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          H_in1,
  input  logic [3:0]          H_in0,
  input  logic [3:0]          M_in1,
  input  logic [3:0]          M_in0,
  input  logic                LD_time,
  input  logic                LD_alarm,
  input  logic [AW-1:0]       AL_SEL,
  input  logic [N_ALARMS-1:0] AL_EN,
  input  logic                AL_ON,
  input  logic                STOP_alarm,
  input  logic                SNOOZE,
  input  logic                MODE_12H,
  output logic                Alarm,
  output logic                snoozed,
  output logic [AW-1:0]       ring_id,
  output logic                ld_err,
  output logic                tick,
  output logic                pm,
  output logic [1:0]          H_out1,
  output logic [3:0]          H_out0,
  output logic [3:0]          M_out1,
  output logic [3:0]          M_out0,
  output logic [3:0]          S_out1,
  output logic [3:0]          S_out0
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam int RW = $clog2(RING_S + 1);
  localparam int SW = $clog2(SNOOZE_S + 1);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

  logic [PW-1:0]       presc_reg;
  logic [4:0]          hour_reg, hour_inc;
  logic [5:0]          min_reg, min_inc;
  logic [5:0]          sec_reg, sec_inc;
  state_t              state_reg, state_next;
  logic [RW-1:0]       ring_cnt_reg, ring_cnt_next;
  logic [SW-1:0]       snooze_cnt_reg, snooze_cnt_next;
  logic [AW-1:0]       ring_id_reg, ring_id_next;
  logic                ld_err_reg;
  logic [N_ALARMS-1:0] match_vec;
  logic                match_any;
  logic [AW-1:0]       match_idx;
  logic [4:0]          disp_hour;

  logic [5:0] in_hour, in_min;
  logic       in_valid, sel_valid, ld_time_ok, ld_alarm_ok, ld_reject, tick_adv;

  // Hours are always entered in 24-hour form; digits above 9 are rejected.
  assign in_hour     = 6'(H_in1) * 6'd10 + 6'(H_in0);
  assign in_min      = 6'(M_in1) * 6'd10 + 6'(M_in0);
  assign in_valid    = (in_hour <= 6'd23) && (H_in0 <= 4'd9) && (M_in1 <= 4'd5) && (M_in0 <= 4'd9);
  assign sel_valid   = (int'(AL_SEL) < N_ALARMS);
  assign ld_time_ok  = LD_time && in_valid;
  assign ld_alarm_ok = LD_alarm && in_valid && sel_valid;
  assign ld_reject   = (LD_time && !in_valid) || (LD_alarm && !(in_valid && sel_valid));

  assign tick     = (presc_reg == PW'(CLK_HZ - 1));
  assign tick_adv = tick && !ld_time_ok;

  always_comb begin
    sec_inc  = sec_reg + 6'd1;
    min_inc  = min_reg;
    hour_inc = hour_reg;
    if (sec_reg == 6'd59) begin
      sec_inc = '0;
      min_inc = min_reg + 6'd1;
      if (min_reg == 6'd59) begin
        min_inc  = '0;
        hour_inc = (hour_reg == 5'd23) ? '0 : hour_reg + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg  <= '0;
      hour_reg   <= '0;
      min_reg    <= '0;
      sec_reg    <= '0;
      ld_err_reg <= 1'b0;
    end else begin
      ld_err_reg <= ld_reject;
      if (ld_time_ok) begin
        presc_reg <= '0;
        hour_reg  <= in_hour[4:0];
        min_reg   <= in_min;
        sec_reg   <= '0;
      end else if (tick) begin
        presc_reg <= '0;
        hour_reg  <= hour_inc;
        min_reg   <= min_inc;
        sec_reg   <= sec_inc;
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
    end
  end

  // Each slot compares against the time it is about to become, at second 0.
  for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_slot
    logic [4:0] slot_hour_reg;
    logic [5:0] slot_min_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        slot_hour_reg <= '0;
        slot_min_reg  <= '0;
      end else if (ld_alarm_ok && (AL_SEL == AW'(gi))) begin
        slot_hour_reg <= in_hour[4:0];
        slot_min_reg  <= in_min;
      end
    end

    assign match_vec[gi] = tick_adv && (sec_inc == 6'd0) && (hour_inc == slot_hour_reg) &&
                           (min_inc == slot_min_reg) && AL_EN[gi] && AL_ON;
  end

  assign match_any = |match_vec;

  always_comb begin
    match_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (match_vec[i]) match_idx = AW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      ring_cnt_reg   <= '0;
      snooze_cnt_reg <= '0;
      ring_id_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      ring_cnt_reg   <= ring_cnt_next;
      snooze_cnt_reg <= snooze_cnt_next;
      ring_id_reg    <= ring_id_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    ring_cnt_next   = ring_cnt_reg;
    snooze_cnt_next = snooze_cnt_reg;
    ring_id_next    = ring_id_reg;
    if (!AL_ON || STOP_alarm) begin
      state_next = IDLE;
    end else if (SNOOZE && (state_reg == RINGING)) begin
      state_next      = SNOOZED;
      snooze_cnt_next = SW'(SNOOZE_S);
    end else if (match_any && (state_reg != RINGING)) begin
      state_next    = RINGING;
      ring_id_next  = match_idx;
      ring_cnt_next = RW'(RING_S);
    end else if (tick) begin
      case (state_reg)
        RINGING: begin
          if (ring_cnt_reg <= RW'(1)) begin
            state_next    = IDLE;
            ring_cnt_next = '0;
          end else begin
            ring_cnt_next = ring_cnt_reg - RW'(1);
          end
        end
        SNOOZED: begin
          if (snooze_cnt_reg <= SW'(1)) begin
            state_next      = RINGING;
            snooze_cnt_next = '0;
            ring_cnt_next   = RW'(RING_S);
          end else begin
            snooze_cnt_next = snooze_cnt_reg - SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    disp_hour = hour_reg;
    if (MODE_12H) begin
      if (hour_reg == 5'd0)       disp_hour = 5'd12;
      else if (hour_reg > 5'd12)  disp_hour = hour_reg - 5'd12;
    end
  end

  assign Alarm   = (state_reg == RINGING);
  assign snoozed = (state_reg == SNOOZED);
  assign ring_id = ring_id_reg;
  assign ld_err  = ld_err_reg;
  assign pm      = (hour_reg >= 5'd12);
  assign H_out1  = 2'(disp_hour / 5'd10);
  assign H_out0  = 4'(disp_hour % 5'd10);
  assign M_out1  = 4'(min_reg / 6'd10);
  assign M_out0  = 4'(min_reg % 6'd10);
  assign S_out1  = 4'(sec_reg / 6'd10);
  assign S_out0  = 4'(sec_reg % 6'd10);

endmodule
